dcache_miss_requester: RTL and testbench
========================================

Name: dcache_miss_requester

Overview:
- Core-side requester for the coherent memory system; one instance per core, between the DCache and the memory op / write-data queues.
- Converts a DCache miss (with optional dirty-victim writeback) into memory ops: flush, read, exclusive read, or SHARED->MODIFIED upgrade.
- Collects the 8-word RD return stream addressed to its core into a 256-bit line and hands it back to the DCache.
- For upgrades, waits for the GrantExclusive message instead of data.

Parameters:
- CORE_ID, 4'd1: this core's destination id (1..nCores, never 0).
- ERR_ON_STRAY, 1: when 1, a stray return word sets protoErr.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- missValid  in  1  miss request present
- missReady  out  1  requester idle; miss accepted when missValid & missReady
- missAddr  in  28  line address
- missExcl  in  1  exclusive read (store miss)
- missUpgrade  in  1  line already held SHARED; request MODIFIED only
- victimValid  in  1  dirty victim must be flushed first
- victimAddr  in  28  victim line address
- victimData  in  256  victim line, word 0 in [31:0]
- wrMemOp  out  1  push memory op
- memOpQfull  in  1  memory op queue full
- memOpDestOut  out  4  always CORE_ID
- memOpDataOut  out  32  {1'b0, upgrade, op[1:0], addr[27:0]}
- wrWriteData  out  1  push write-data beat
- writeDataQfull  in  1  write-data queue full
- writeDataOut  out  128  write beat
- RDreturn  in  32  return word
- RDdest  in  4  return destination; 0 means no word
- grantValid  in  1  GrantExclusive message for this core
- grantAddr  in  28  granted line address
- fillValid  out  1  one-cycle pulse, line complete
- fillData  out  256  assembled line, word 0 in [31:0]
- fillAddr  out  28  address of the filled line
- protoErr  out  1  sticky protocol error

Behaviour:
- Op encoding in memOpDataOut[29:28]: 00 flush, 01 read, 11 exclusive read. Bit 31 is always 0; memory sets it on resend. Bit 30 = upgrade.
- Reset: state IDLE; every output 0 except memOpDestOut = CORE_ID; missReady = 1 on the cycle after reset deasserts.
- missReady = (state == IDLE). On acceptance, latch missAddr/excl/upgrade/victim fields.
- Next state from IDLE on acceptance: FLUSH_OP if victimValid, else REQ_OP.
- FLUSH_OP:
  - When ~memOpQfull & ~writeDataQfull: assert wrMemOp with op 00 on victimAddr.
  - In the same cycle, wrWriteData with victimData[127:0]; go to FLUSH_D1.
- FLUSH_D1: when ~writeDataQfull, wrWriteData with victimData[255:128]; go to REQ_OP.
- REQ_OP:
  - When ~memOpQfull: assert wrMemOp.
  - Op = 11 if excl or upgrade, else 01; bit 30 = upgrade.
  - Next state: WAIT_GRANT if upgrade, else WAIT_DATA. Clear the word counter (3 bits).
- Queue pushes are combinational from state and full flags; never push while the matching full input is high.
- WAIT_DATA:
  - Each cycle with RDdest == CORE_ID, store RDreturn into word slot [cnt] and increment cnt.
  - Gaps between words are allowed. Words arrive in order, word 0 first.
  - On the 8th word (cnt == 7), go to FILL.
- FILL: fillValid = 1 for exactly one cycle with fillData/fillAddr; return to IDLE. Latency from 8th word to fillValid is 1 cycle.
- WAIT_GRANT:
  - grantValid with grantAddr == latched addr -> FILL with fillData = 0.
  - The DCache keeps its own data; fillValid signals permission only.
  - grantValid with a mismatched address is ignored and sets protoErr.
- RD input cannot be back-pressured and must be sampled every cycle in every state.
- Stray word (RDdest == CORE_ID outside WAIT_DATA): dropped; sets protoErr if ERR_ON_STRAY.
- Memory resends are invisible to this block; WAIT_DATA/WAIT_GRANT wait indefinitely.
- protoErr clears only on reset.
- Reset mid-operation returns to IDLE next cycle and discards partial line, counter and pending pushes; no queue push occurs in the reset cycle.
- One outstanding miss maximum.

Test Plan:
- Clean read: miss addr 0x0000123, no victim, queues empty -> wrMemOp cycle 1 with data 0x10000123. Then 8 words 0x11..0x88 with RDdest = 1 -> fillValid once, fillData[31:0] = 0x11, [255:224] = 0x88.
- Victim flush + exclusive read:
  - victim 0x40, data words k = k, miss excl 0x80.
  - Expect push order: op 0x00000040 with beat 0 {3,2,1,0}; then beat 1 {7,6,5,4}; then op 0x30000080. No fill before 8 words.
- Back-pressure:
  - memOpQfull held high 5 cycles in REQ_OP -> no wrMemOp during those cycles.
  - writeDataQfull high in FLUSH_D1 -> beat 1 stalls, no duplicate beat.
- Upgrade: missUpgrade, addr 0x200 -> op 0x70000200. grantAddr 0x201 -> ignored, protoErr = 1. grantAddr 0x200 -> fillValid, fillData = 0.
- Interleaved traffic: words for RDdest = 2 interleaved with 3-cycle gaps -> only CORE_ID words assembled, correct order.
- Stray word in IDLE sets protoErr.
- Reset after 4 of 8 words -> IDLE and missReady next cycle. Old words arriving afterwards are stray; a new miss completes correctly with fresh data.

Source files
------------

// File: rtl/dcache_miss_requester.sv
// dcache_miss_requester: turns a DCache miss into flush/read/upgrade memory ops
// and assembles the 8-word RD return stream into a 256-bit fill line.
module dcache_miss_requester #(
  parameter logic [3:0] CORE_ID      = 4'd1,
  parameter bit         ERR_ON_STRAY = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         missValid,
  output logic         missReady,
  input  logic [27:0]  missAddr,
  input  logic         missExcl,
  input  logic         missUpgrade,
  input  logic         victimValid,
  input  logic [27:0]  victimAddr,
  input  logic [255:0] victimData,
  output logic         wrMemOp,
  input  logic         memOpQfull,
  output logic [3:0]   memOpDestOut,
  output logic [31:0]  memOpDataOut,
  output logic         wrWriteData,
  input  logic         writeDataQfull,
  output logic [127:0] writeDataOut,
  input  logic [31:0]  RDreturn,
  input  logic [3:0]   RDdest,
  input  logic         grantValid,
  input  logic [27:0]  grantAddr,
  output logic         fillValid,
  output logic [255:0] fillData,
  output logic [27:0]  fillAddr,
  output logic         protoErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH_OP,
    S_FLUSH_D1,
    S_REQ_OP,
    S_WAIT_DATA,
    S_WAIT_GRANT,
    S_FILL
  } state_e;

  state_e         state_q, state_d;
  logic [27:0]    addr_q, vaddr_q;
  logic           excl_q, upg_q;
  logic [255:0]   vdata_q, line_q;
  logic [2:0]     cnt_q;
  logic           err_q;

  logic accept, rd_hit, grant_hit, grant_bad, stray;

  assign accept    = missValid & (state_q == S_IDLE);
  assign rd_hit    = (RDdest == CORE_ID);
  assign grant_hit = grantValid & (grantAddr == addr_q);
  assign grant_bad = (state_q == S_WAIT_GRANT) & grantValid
                   & (grantAddr != addr_q);
  assign stray     = ERR_ON_STRAY & rd_hit & (state_q != S_WAIT_DATA);

  assign memOpDestOut = CORE_ID;
  assign protoErr     = err_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (missValid)
          state_d = victimValid ? S_FLUSH_OP : S_REQ_OP;
      S_FLUSH_OP:
        if (~memOpQfull & ~writeDataQfull) state_d = S_FLUSH_D1;
      S_FLUSH_D1:
        if (~writeDataQfull) state_d = S_REQ_OP;
      S_REQ_OP:
        if (~memOpQfull)
          state_d = upg_q ? S_WAIT_GRANT : S_WAIT_DATA;
      S_WAIT_DATA:
        if (rd_hit && cnt_q == 3'd7) state_d = S_FILL;
      S_WAIT_GRANT:
        if (grant_hit) state_d = S_FILL;
      S_FILL:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Reset masks every output so nothing is pushed in the reset cycle.
  always_comb begin
    missReady    = 1'b0;
    wrMemOp      = 1'b0;
    memOpDataOut = '0;
    wrWriteData  = 1'b0;
    writeDataOut = '0;
    fillValid    = 1'b0;
    fillData     = '0;
    fillAddr     = '0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE: missReady = 1'b1;
        S_FLUSH_OP: begin
          wrMemOp      = ~memOpQfull & ~writeDataQfull;
          wrWriteData  = ~memOpQfull & ~writeDataQfull;
          memOpDataOut = {4'b0000, vaddr_q};
          writeDataOut = vdata_q[127:0];
        end
        S_FLUSH_D1: begin
          wrWriteData  = ~writeDataQfull;
          writeDataOut = vdata_q[255:128];
        end
        S_REQ_OP: begin
          wrMemOp      = ~memOpQfull;
          memOpDataOut = {1'b0, upg_q, excl_q | upg_q, 1'b1, addr_q};
        end
        S_FILL: begin
          fillValid = 1'b1;
          fillData  = upg_q ? '0 : line_q;
          fillAddr  = addr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      vaddr_q <= '0;
      excl_q  <= 1'b0;
      upg_q   <= 1'b0;
      vdata_q <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= missAddr;
        excl_q  <= missExcl;
        upg_q   <= missUpgrade;
        vaddr_q <= victimAddr;
        vdata_q <= victimData;
      end
      if (state_q == S_REQ_OP) cnt_q <= '0;
      if (state_q == S_WAIT_DATA && rd_hit) begin
        line_q[{cnt_q, 5'd0} +: 32] <= RDreturn;
        cnt_q                       <= cnt_q + 3'd1;
      end
      if (stray || grant_bad) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_miss_requester.sv
// tb_dcache_miss_requester: random + directed misses checked against
// transaction-level expectation queues for ops, write beats and fills.
module tb_dcache_miss_requester;
  localparam logic [3:0] CID = 4'd1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         missValid = 1'b0;
  logic         missReady;
  logic [27:0]  missAddr = '0;
  logic         missExcl = 1'b0;
  logic         missUpgrade = 1'b0;
  logic         victimValid = 1'b0;
  logic [27:0]  victimAddr = '0;
  logic [255:0] victimData = '0;
  logic         wrMemOp;
  logic         memOpQfull = 1'b0;
  logic [3:0]   memOpDestOut;
  logic [31:0]  memOpDataOut;
  logic         wrWriteData;
  logic         writeDataQfull = 1'b0;
  logic [127:0] writeDataOut;
  logic [31:0]  RDreturn = '0;
  logic [3:0]   RDdest = '0;
  logic         grantValid = 1'b0;
  logic [27:0]  grantAddr = '0;
  logic         fillValid;
  logic [255:0] fillData;
  logic [27:0]  fillAddr;
  logic         protoErr;

  dcache_miss_requester #(.CORE_ID(CID), .ERR_ON_STRAY(1'b1)) dut (
    .clock(clock), .reset(reset),
    .missValid(missValid), .missReady(missReady),
    .missAddr(missAddr), .missExcl(missExcl),
    .missUpgrade(missUpgrade), .victimValid(victimValid),
    .victimAddr(victimAddr), .victimData(victimData),
    .wrMemOp(wrMemOp), .memOpQfull(memOpQfull),
    .memOpDestOut(memOpDestOut), .memOpDataOut(memOpDataOut),
    .wrWriteData(wrWriteData), .writeDataQfull(writeDataQfull),
    .writeDataOut(writeDataOut),
    .RDreturn(RDreturn), .RDdest(RDdest),
    .grantValid(grantValid), .grantAddr(grantAddr),
    .fillValid(fillValid), .fillData(fillData),
    .fillAddr(fillAddr), .protoErr(protoErr)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit bp_en = 1'b0;

  logic [31:0]  exp_op[$];
  logic [127:0] exp_bt[$];
  logic [255:0] exp_fd[$];
  logic [27:0]  exp_fa[$];

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (wrMemOp) begin
      chk("op_while_full", 256'(memOpQfull), 256'(0));
      if (exp_op.size() == 0) chk("op_unexp", 256'(exp_op.size()), 256'(1));
      else chk("op_data", 256'(memOpDataOut), 256'(exp_op.pop_front()));
    end
    if (wrWriteData) begin
      chk("wd_while_full", 256'(writeDataQfull), 256'(0));
      if (exp_bt.size() == 0) chk("wd_unexp", 256'(exp_bt.size()), 256'(1));
      else chk("wd_data", 256'(writeDataOut), 256'(exp_bt.pop_front()));
    end
    if (fillValid) begin
      if (exp_fd.size() == 0) chk("fill_unexp", 256'(exp_fd.size()), 256'(1));
      else begin
        chk("fill_data", fillData, exp_fd.pop_front());
        chk("fill_addr", 256'(fillAddr), 256'(exp_fa.pop_front()));
      end
    end
  end

  initial forever begin
    @(posedge clock); #1;
    if (bp_en) begin
      memOpQfull     = ($urandom_range(0, 2) == 0);
      writeDataQfull = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic issue(input logic [27:0] a, input bit ex, input bit up,
                       input bit vic, input logic [27:0] va,
                       input logic [255:0] vd);
    int n = 0;
    tick();
    missAddr = a; missExcl = ex; missUpgrade = up;
    victimValid = vic; victimAddr = va; victimData = vd;
    missValid = 1'b1;
    @(negedge clock);
    while (!missReady && n < 300) begin @(negedge clock); n++; end
    if (!missReady) chk("ready_timeout", 256'(missReady), 256'(1));
    if (vic) begin
      exp_op.push_back({4'b0000, va});
      exp_bt.push_back(vd[127:0]);
      exp_bt.push_back(vd[255:128]);
    end
    exp_op.push_back({1'b0, up, ex | up, 1'b1, a});
    tick();
    missValid = 1'b0; victimValid = 1'b0;
  endtask

  task automatic wait_ops();
    int n = 0;
    while ((exp_op.size() + exp_bt.size()) != 0 && n < 300) begin
      tick(); n++;
    end
    chk("ops_drained", 256'(exp_op.size() + exp_bt.size()), 256'(0));
  endtask

  task automatic wait_fill();
    int n = 0;
    while (exp_fd.size() != 0 && n < 50) begin tick(); n++; end
    chk("fill_seen", 256'(exp_fd.size()), 256'(0));
  endtask

  task automatic send_words(input logic [31:0] w [8], input int lo,
                            input int hi, input logic [27:0] a,
                            input bit do_fill);
    logic [255:0] line;
    for (int k = 0; k < 8; k++) line[32*k +: 32] = w[k];
    for (int i = lo; i <= hi; i++) begin
      repeat ($urandom_range(0, 3)) begin
        RDdest   = $urandom_range(0, 1) ? 4'd2 : 4'd0;
        RDreturn = $urandom;
        tick();
      end
      RDdest = CID; RDreturn = w[i];
      if (i == 7 && do_fill) begin
        exp_fd.push_back(line);
        exp_fa.push_back(a);
      end
      tick();
    end
    RDdest = 4'd0; RDreturn = '0;
  endtask

  task automatic grant(input logic [27:0] a);
    grantValid = 1'b1; grantAddr = a;
    tick();
    grantValid = 1'b0; grantAddr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_op.delete(); exp_bt.delete(); exp_fd.delete(); exp_fa.delete();
    @(negedge clock);
    chk("rst_ready", 256'(missReady), 256'(0));
    chk("rst_memop", 256'(wrMemOp), 256'(0));
    chk("rst_wd", 256'(wrWriteData), 256'(0));
    chk("rst_fill", 256'(fillValid), 256'(0));
    chk("rst_dest", 256'(memOpDestOut), 256'(CID));
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 256'(missReady), 256'(1));
    chk("post_rst_perr", 256'(protoErr), 256'(0));
    tick();
  endtask

  logic [31:0]  w [8];
  logic [255:0] vd;
  logic [27:0]  a;
  bit           ex, up, vic;

  initial begin
    tick();
    do_reset();

    issue(28'h0000123, 0, 0, 0, '0, '0);
    @(negedge clock);
    chk("op_cycle1", 256'(wrMemOp), 256'(1));
    chk("op_clean", 256'(memOpDataOut), 256'(32'h10000123));
    tick();
    wait_ops();
    for (int k = 0; k < 8; k++) w[k] = 32'h11 * (k + 1);
    send_words(w, 0, 7, 28'h0000123, 1);
    wait_fill();
    chk("perr_clean", 256'(protoErr), 256'(0));

    for (int k = 0; k < 8; k++) vd[32*k +: 32] = k;
    issue(28'h80, 1, 0, 1, 28'h40, vd);
    tick();
    writeDataQfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("d1_stall", 256'(wrWriteData), 256'(0));
      tick();
    end
    writeDataQfull = 1'b0; memOpQfull = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("req_stall", 256'(wrMemOp), 256'(0));
      tick();
    end
    memOpQfull = 1'b0;
    wait_ops();
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    send_words(w, 0, 7, 28'h80, 1);
    wait_fill();

    issue(28'h200, 0, 1, 0, '0, '0);
    wait_ops();
    tick();
    grant(28'h201);
    chk("perr_badgrant", 256'(protoErr), 256'(1));
    chk("no_fill_badgrant", 256'(fillValid), 256'(0));
    exp_fd.push_back('0); exp_fa.push_back(28'h200);
    grant(28'h200);
    wait_fill();

    do_reset();
    RDdest = CID; RDreturn = 32'hdead;
    tick();
    RDdest = 4'd0; RDreturn = '0;
    chk("perr_stray", 256'(protoErr), 256'(1));

    do_reset();
    a = 28'h0abcdef;
    issue(a, 0, 0, 0, '0, '0);
    wait_ops();
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    send_words(w, 0, 3, a, 0);
    do_reset();
    send_words(w, 4, 7, a, 0);
    chk("perr_late_words", 256'(protoErr), 256'(1));
    chk("no_fill_late", 256'(exp_fd.size()), 256'(0));
    issue(a, 0, 0, 0, '0, '0);
    wait_ops();
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    send_words(w, 0, 7, a, 1);
    wait_fill();

    do_reset();
    bp_en = 1'b1;
    for (int it = 0; it < 24; it++) begin
      a   = 28'($urandom);
      ex  = $urandom_range(0, 1);
      up  = ($urandom_range(0, 3) == 0);
      vic = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 8; k++) vd[32*k +: 32] = $urandom;
      issue(a, ex, up, vic, 28'($urandom), vd);
      wait_ops();
      if (up) begin
        repeat ($urandom_range(0, 4)) tick();
        exp_fd.push_back('0); exp_fa.push_back(a);
        grant(a);
      end else begin
        for (int k = 0; k < 8; k++) w[k] = $urandom;
        send_words(w, 0, 7, a, 1);
      end
      wait_fill();
    end
    bp_en = 1'b0;
    tick();
    memOpQfull = 1'b0; writeDataQfull = 1'b0;
    repeat (3) tick();
    chk("final_perr", 256'(protoErr), 256'(0));
    chk("final_q", 256'(exp_op.size() + exp_bt.size() + exp_fd.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
